// File: rtl/tdc_timestamp_packer.sv
// tdc_timestamp_packer: pairs adder-tree fine codes with a latency-compensated coarse count and buffers them in a FIFO.
// Optional feature: define TDC_TS_DROP_CNT_EN to add o_Drop_Count, a saturating count of dropped events.
module tdc_timestamp_packer #(
    parameter int WIDTH_FINE   = 17,
    parameter int WIDTH_COARSE = 24,
    parameter int TREE_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Reset_N,
    input  logic [WIDTH_FINE-1:0]                i_Fine_Code,
    input  logic                                 i_Fine_Valid,
    input  logic                                 i_Coarse_Clear,
    output logic [WIDTH_COARSE+WIDTH_FINE-1:0]   o_Ts_Data,
    output logic                                 o_Ts_Valid,
    input  logic                                 i_Ts_Ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      o_Fifo_Level,
    output logic                                 o_Overflow,
    input  logic                                 i_Overflow_Clr,
`ifdef TDC_TS_DROP_CNT_EN
    output logic [15:0]                          o_Drop_Count,
`endif
    output logic                                 o_Coarse_Wrap
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = WIDTH_COARSE + WIDTH_FINE;

    logic [WIDTH_COARSE-1:0] cnt;
    logic [WIDTH_COARSE-1:0] hist [TREE_LATENCY];
    logic [DW-1:0]           mem  [FIFO_DEPTH];
    logic [PW-1:0]           wptr, rptr;
    logic                    full, empty, rd, wr, drop;

    assign empty      = wptr == rptr;
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd         = !empty && i_Ts_Ready;
    assign wr         = i_Fine_Valid && (!full || rd);
    assign drop       = i_Fine_Valid && full && !rd;
    assign o_Ts_Valid = !empty;
    assign o_Ts_Data  = mem[rptr[AW-1:0]];

    // Free-running coarse counter; wrap pulse accompanies the natural roll-over to 0, never a clear.
    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            cnt           <= '0;
            o_Coarse_Wrap <= 1'b0;
        end else begin
            cnt           <= i_Coarse_Clear ? '0 : cnt + WIDTH_COARSE'(1);
            o_Coarse_Wrap <= !i_Coarse_Clear && (cnt == '1);
        end
    end

    // Counter history so a hit leaving the tree is stamped with the count from when it was sampled.
    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            for (int i = 0; i < TREE_LATENCY; i++) hist[i] <= '0;
        end else begin
            hist[0] <= cnt;
            for (int i = 1; i < TREE_LATENCY; i++) hist[i] <= hist[i-1];
        end
    end

    // Timestamp FIFO storage, pointers and occupancy.
    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr         <= '0;
            rptr         <= '0;
            o_Fifo_Level <= '0;
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= {hist[TREE_LATENCY-1], i_Fine_Code};
                wptr              <= wptr + PW'(1);
            end
            if (rd) rptr <= rptr + PW'(1);
            if (wr && !rd) o_Fifo_Level <= o_Fifo_Level + LW'(1);
            else if (rd && !wr) o_Fifo_Level <= o_Fifo_Level - LW'(1);
        end
    end

    // Sticky overflow flag; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) o_Overflow <= 1'b0;
        else o_Overflow <= drop ? 1'b1 : (i_Overflow_Clr ? 1'b0 : o_Overflow);
    end

`ifdef TDC_TS_DROP_CNT_EN
    // Saturating drop counter; a drop coinciding with a clear restarts the count at 1.
    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) o_Drop_Count <= '0;
        else if (drop) o_Drop_Count <= i_Overflow_Clr ? 16'd1 : (o_Drop_Count == 16'hFFFF ? o_Drop_Count : o_Drop_Count + 16'd1);
        else if (i_Overflow_Clr) o_Drop_Count <= '0;
    end
`endif
endmodule

// File: tb/tb_tdc_timestamp_packer.sv
// tb_tdc_timestamp_packer: directed scoreboard bench; an 8-bit coarse counter keeps the wrap test short.
module tb_tdc_timestamp_packer;
    localparam int WF = 17;
    localparam int WC = 8;
    localparam int TL = 3;
    localparam int FD = 8;
    localparam int DW = WC + WF;
    localparam int LW = $clog2(FD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WF-1:0] fine = '0;
    logic          fvalid = 1'b0;
    logic          cclear = 1'b0;
    logic          ready = 1'b0;
    logic          oclr = 1'b0;
    logic [DW-1:0] ts_data;
    logic          ts_valid;
    logic [LW-1:0] level;
    logic          ovf;
    logic          wrap;
`ifdef TDC_TS_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    int checks = 0;
    int errors = 0;
    int wrap_seen = 0;
    logic [WC-1:0] mcnt;
    logic [WC-1:0] mhist [TL];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] e;

    tdc_timestamp_packer #(
        .WIDTH_FINE(WF), .WIDTH_COARSE(WC), .TREE_LATENCY(TL), .FIFO_DEPTH(FD)
    ) dut (
        .i_Clk(clk),
        .i_Reset_N(rst_n),
        .i_Fine_Code(fine),
        .i_Fine_Valid(fvalid),
        .i_Coarse_Clear(cclear),
        .o_Ts_Data(ts_data),
        .o_Ts_Valid(ts_valid),
        .i_Ts_Ready(ready),
        .o_Fifo_Level(level),
        .o_Overflow(ovf),
        .i_Overflow_Clr(oclr),
`ifdef TDC_TS_DROP_CNT_EN
        .o_Drop_Count(drop_count),
`endif
        .o_Coarse_Wrap(wrap)
    );

    always #5 clk = ~clk;

    // Reference coarse counter and its latency history.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= '0;
            for (int i = 0; i < TL; i++) mhist[i] <= '0;
        end else begin
            mcnt <= cclear ? '0 : mcnt + 8'd1;
            mhist[0] <= mcnt;
            for (int i = 1; i < TL; i++) mhist[i] <= mhist[i-1];
        end
    end

    // Count every cycle the wrap pulse is seen high.
    always @(negedge clk) if (wrap === 1'b1) wrap_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hit(input logic [WF-1:0] f, input bit accept);
        fvalid = 1'b1;
        fine = f;
        if (accept) exp_q.push_back({mhist[TL-1], f});
        tick();
        fvalid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [DW-1:0] x;
        check({tag, "_valid"}, 64'(ts_valid), 64'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue obs=empty exp=entry", tag);
        end else begin
            x = exp_q.pop_front();
            check({tag, "_data"}, 64'(ts_data), 64'(x));
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_valid", 64'(ts_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("rst_data", 64'(ts_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First hit at counter 10 carries coarse 7.
        repeat (10) tick();
        e = {8'd7, 17'h00123};
        exp_q.push_back(e);
        hit(17'h00123, 1'b0);
        check("first_valid", 64'(ts_valid), 64'd1);
        check("first_data", 64'(ts_data), 64'(e));
        check("first_level", 64'(level), 64'd1);
        pop_check("first_pop");

        // Fill, overflow on the ninth hit, drain in order.
        for (int i = 0; i < FD; i++) hit(WF'(17'h01000 + i), 1'b1);
        check("fill_level", 64'(level), 64'd8);
        check("fill_ovf", 64'(ovf), 64'd0);
        hit(17'h1FFFF, 1'b0);
        check("ovf_level", 64'(level), 64'd8);
        check("ovf_set", 64'(ovf), 64'd1);
`ifdef TDC_TS_DROP_CNT_EN
        check("ovf_drop_cnt", 64'(drop_count), 64'd1);
`endif
        for (int i = 0; i < FD; i++) pop_check("drain");
        check("drain_valid", 64'(ts_valid), 64'd0);
        check("drain_level", 64'(level), 64'd0);

        // Full FIFO with simultaneous read and write: no drop.
        oclr = 1'b1;
        tick();
        oclr = 1'b0;
        check("clr_ovf", 64'(ovf), 64'd0);
`ifdef TDC_TS_DROP_CNT_EN
        check("clr_drop_cnt", 64'(drop_count), 64'd0);
`endif
        for (int i = 0; i < FD; i++) hit(WF'(17'h02000 + i), 1'b1);
        e = exp_q.pop_front();
        check("rw_head", 64'(ts_data), 64'(e));
        fvalid = 1'b1;
        fine = 17'h0ABCD;
        exp_q.push_back({mhist[TL-1], fine});
        ready = 1'b1;
        tick();
        fvalid = 1'b0;
        ready = 1'b0;
        check("rw_level", 64'(level), 64'd8);
        check("rw_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < FD; i++) pop_check("rw_drain");
        check("rw_empty", 64'(ts_valid), 64'd0);

        // Coarse wrap: clear, run to 2^WC-2, wrap, hit two cycles after wrap.
        cclear = 1'b1;
        tick();
        cclear = 1'b0;
        check("clear_wrap", 64'(wrap), 64'd0);
        repeat (254) tick();
        tick();
        tick();
        tick();
        tick();
        e = {8'hFF, 17'h05A5A};
        exp_q.push_back(e);
        hit(17'h05A5A, 1'b0);
        pop_check("wrap_hit");
        tick();
        check("wrap_once", 64'(wrap_seen), 64'd1);
        while (mcnt != 8'hFF) tick();
        cclear = 1'b1;
        tick();
        cclear = 1'b0;
        tick();
        tick();
        check("clear_at_max_no_wrap", 64'(wrap_seen), 64'd1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) hit(WF'(17'h03000 + i), 1'b1);
        check("pre_rst_level", 64'(level), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(ts_valid), 64'd0);
        check("async_level", 64'(level), 64'd0);
        check("async_data", 64'(ts_data), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        hit(17'h00777, 1'b1);
        check("post_rst_level", 64'(level), 64'd1);
        pop_check("post_rst");

        // Clear coinciding with a new drop.
        for (int i = 0; i < FD; i++) hit(WF'(17'h04000 + i), 1'b1);
        hit(17'h1EEEE, 1'b0);
        check("drop1_ovf", 64'(ovf), 64'd1);
        oclr = 1'b1;
        hit(17'h1DDDD, 1'b0);
        oclr = 1'b0;
        check("setclr_ovf", 64'(ovf), 64'd1);
`ifdef TDC_TS_DROP_CNT_EN
        check("setclr_drop_cnt", 64'(drop_count), 64'd1);
`endif
        oclr = 1'b1;
        tick();
        oclr = 1'b0;
        check("final_clr_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < FD; i++) pop_check("final_drain");
        check("final_empty", 64'(ts_valid), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
